// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: phase codes, state type and opcode class shared by the sequencer and the decode controller.
// Latency: none (constants and types only).
// Backpressure: none.
package cpu_seq_pkg;

    localparam logic [2:0] T_IDLE    = 3'b100;
    localparam logic [2:0] T_FETCH_A = 3'b000;
    localparam logic [2:0] T_FETCH_D = 3'b001;
    localparam logic [2:0] T_EXEC    = 3'b011;
    localparam logic [2:0] T_MEM_A   = 3'b101;
    localparam logic [2:0] T_MEM_D   = 3'b111;

    // ir_op[7:2] of the memory-access opcodes 0x80..0x83
    localparam logic [5:0] OP_MEM_CLASS = 6'b100000;

    // State values are the phase codes, so the state register drives timer directly.
    typedef enum logic [2:0] {
        S_IDLE    = T_IDLE,
        S_FETCH_A = T_FETCH_A,
        S_FETCH_D = T_FETCH_D,
        S_EXEC    = T_EXEC,
        S_MEM_A   = T_MEM_A,
        S_MEM_D   = T_MEM_D
    } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control, phase and memory-handshake signals between sequencer, controller and memory; step pins exist under SEQ_SINGLE_STEP_EN.
// Latency: none (wires only).
// Backpressure: mem_ready is the only stall input; the sequencer holds its wait phase until it arrives or times out.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             halt_req;
    logic [7:0]       ir_op;
    logic             mem_ready;
    logic [2:0]       timer;
    logic             ir_load;
    logic             mem_req;
    logic             busy;
    logic             bus_err;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_cnt;

`ifdef SEQ_SINGLE_STEP_EN
    logic             step_mode;
    logic             step;

    modport master (
        input  run, halt_req, ir_op, mem_ready, step_mode, step,
        output timer, ir_load, mem_req, busy, bus_err, instr_retired, retired_cnt
    );
    modport slave (
        output run, halt_req, ir_op, mem_ready, step_mode, step,
        input  timer, ir_load, mem_req, busy, bus_err, instr_retired, retired_cnt
    );
`else
    modport master (
        input  run, halt_req, ir_op, mem_ready,
        output timer, ir_load, mem_req, busy, bus_err, instr_retired, retired_cnt
    );
    modport slave (
        output run, halt_req, ir_op, mem_ready,
        input  timer, ir_load, mem_req, busy, bus_err, instr_retired, retired_cnt
    );
`endif

endinterface

// File: rtl/seq_wait_timer.sv
// seq_wait_timer: counts stalled cycles of a memory wait phase and flags a bus timeout.
// Latency: count updates on each clk edge; timeout is combinational from the count and mem_ready.
// Backpressure: none; observes mem_ready only. WAIT_MAX = 0 disables the timeout.
module seq_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic mem_ready,
    output logic timeout
);
    localparam int            CW    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

    logic [CW-1:0] cnt;

    // Count stalled cycles from zero on every wait-phase entry; hold at LIMIT instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !mem_ready && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // WAIT_MAX stalled cycles have already elapsed and memory is still not ready; a late mem_ready wins.
    assign timeout = (WAIT_MAX != 0) && enable && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: drives the fetch/execute/memory phase code, IR load strobe and retire counter; single-step mode under SEQ_SINGLE_STEP_EN.
// Latency: 3 cycles per non-memory instruction, 5 per memory instruction with zero wait-states.
// Backpressure: stalls in FETCH_D/MEM_D until mem_ready; after WAIT_MAX stalled cycles aborts to IDLE with bus_err.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);
    state_t           state;
    state_t           state_nxt;
    logic             bus_err;
    logic             bus_err_nxt;
    logic [CNT_W-1:0] retired_cnt;
    logic             in_wait;
    logic             timeout;
    logic             retire;
    logic             ir_load;
    logic             mem_req;
    logic             start_req;
    logic             stop_after_retire;
    logic             is_mem_op;
    logic [1:0]       unused_op_lsb;

    // The low opcode bits only select the address source, which is the controller's business.
    assign unused_op_lsb = bus.ir_op[1:0];
    assign is_mem_op     = (bus.ir_op[7:2] == OP_MEM_CLASS);

`ifdef SEQ_SINGLE_STEP_EN
    logic one_shot;
    logic one_shot_nxt;

    assign start_req         = bus.run | bus.step;
    assign stop_after_retire = bus.halt_req | bus.step_mode | one_shot;
`else
    assign start_req         = bus.run;
    assign stop_after_retire = bus.halt_req;
`endif

    assign in_wait = (state == S_FETCH_D) || (state == S_MEM_D);

    seq_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (!in_wait),
        .enable    (in_wait),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    // Next phase, IR strobe, memory request and retire decision for the current phase.
    always_comb begin
        state_nxt   = state;
        bus_err_nxt = bus_err;
        retire      = 1'b0;
        ir_load     = 1'b0;
        mem_req     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        one_shot_nxt = one_shot;
`endif
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nxt   = S_FETCH_A;
                    bus_err_nxt = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    // A bare step runs one instruction; run alongside it means free-running.
                    one_shot_nxt = bus.step & ~bus.run;
`endif
                end
            end
            S_FETCH_A: state_nxt = S_FETCH_D;
            S_FETCH_D: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_load   = 1'b1;
                    state_nxt = S_EXEC;
                end else if (timeout) begin
                    state_nxt   = S_IDLE;
                    bus_err_nxt = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_mem_op) begin
                    state_nxt = S_MEM_A;
                end else begin
                    retire    = 1'b1;
                    state_nxt = stop_after_retire ? S_IDLE : S_FETCH_A;
                end
            end
            S_MEM_A: state_nxt = S_MEM_D;
            S_MEM_D: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = stop_after_retire ? S_IDLE : S_FETCH_A;
                end else if (timeout) begin
                    state_nxt   = S_IDLE;
                    bus_err_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase register, sticky bus error and wrapping retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bus_err     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bus_err <= bus_err_nxt;
            if (retire) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    // Remember whether the current run was started by a single step.
    always_ff @(posedge clk) begin
        if (rst) begin
            one_shot <= 1'b0;
        end else begin
            one_shot <= one_shot_nxt;
        end
    end
`endif

    assign bus.timer         = state;
    assign bus.busy          = (state != S_IDLE);
    assign bus.ir_load       = ir_load;
    assign bus.mem_req       = mem_req;
    assign bus.instr_retired = retire;
    assign bus.bus_err       = bus_err;
    assign bus.retired_cnt   = retired_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed literal scenarios plus randomized traffic against an instruction-level reference model.
// Latency: n/a.
// Backpressure: mem_ready is randomized with long low streaks to provoke timeouts.
module tb_cpu_sequencer;
    localparam int WMAX = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cpu_sequencer_if #(.CNT_W(CW)) bus ();

    cpu_sequencer #(
        .WAIT_MAX (WMAX),
        .CNT_W    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] m_timer;
    int         m_wait;
    int         m_cnt;
    bit         m_err;
    bit         m_one;
    bit         m_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_mem(input logic [7:0] op);
        return op[7:2] == 6'b100000;
    endfunction

    task automatic model_retire(input bit go_idle);
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_timer = go_idle ? 3'b100 : 3'b000;
    endtask

    task automatic model_cycle();
        bit exp_ret;
        bit go_idle;
        if (m_valid) begin
            exp_ret = (m_timer == 3'b011 && !is_mem(bus.ir_op)) || (m_timer == 3'b111 && bus.mem_ready);
            chk("m_timer",   bus.timer, m_timer);
            chk("m_busy",    bus.busy, m_timer != 3'b100);
            chk("m_mem_req", bus.mem_req, m_timer == 3'b001 || m_timer == 3'b111);
            chk("m_ir_load", bus.ir_load, m_timer == 3'b001 && bus.mem_ready);
            chk("m_retire",  bus.instr_retired, exp_ret);
            chk("m_bus_err", bus.bus_err, m_err);
            chk("m_cnt",     bus.retired_cnt, m_cnt);
        end
`ifdef SEQ_SINGLE_STEP_EN
        go_idle = bus.halt_req || bus.step_mode || m_one;
`else
        go_idle = bus.halt_req;
`endif
        if (rst) begin
            m_timer = 3'b100; m_wait = 0; m_cnt = 0; m_err = 0; m_one = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_timer)
                3'b100: begin
`ifdef SEQ_SINGLE_STEP_EN
                    if (bus.run || bus.step) begin
                        m_timer = 3'b000; m_err = 0; m_one = bus.step && !bus.run;
                    end
`else
                    if (bus.run) begin
                        m_timer = 3'b000; m_err = 0;
                    end
`endif
                end
                3'b000: begin m_timer = 3'b001; m_wait = 0; end
                3'b001: begin
                    if (bus.mem_ready) m_timer = 3'b011;
                    else if (WMAX != 0 && m_wait == WMAX) begin m_timer = 3'b100; m_err = 1; end
                    else m_wait++;
                end
                3'b011: begin
                    if (is_mem(bus.ir_op)) m_timer = 3'b101;
                    else model_retire(go_idle);
                end
                3'b101: begin m_timer = 3'b111; m_wait = 0; end
                3'b111: begin
                    if (bus.mem_ready) model_retire(go_idle);
                    else if (WMAX != 0 && m_wait == WMAX) begin m_timer = 3'b100; m_err = 1; end
                    else m_wait++;
                end
                default: m_timer = 3'bxxx;
            endcase
        end
    endtask

    // Every cycle: compare DUT outputs with the model, then advance the model past the next edge.
    always @(negedge clk) model_cycle();

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            cyc();
            n++;
        end
        chk(nm, bus.busy, 1'b0);
    endtask

    logic [2:0] seq_alu [6] = '{3'b000, 3'b001, 3'b011, 3'b000, 3'b001, 3'b011};
    logic [2:0] seq_mem [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b000};
    logic       ret_mem [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] cnt_mem [6] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    logic [2:0] seq_to  [7] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

    initial begin
        int pulses;
        int c0;
        rst = 1'b1;
        bus.run = 0; bus.halt_req = 0; bus.ir_op = 8'h00; bus.mem_ready = 0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step_mode = 0; bus.step = 0;
`endif
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_timer", bus.timer, 3'b100);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_cnt", bus.retired_cnt, 0);
        chk("rst_err", bus.bus_err, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);

        // Back-to-back non-memory instructions with zero wait-states.
        cyc();
        bus.run = 1; bus.ir_op = 8'h00; bus.mem_ready = 1;
        cyc();
        bus.run = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alu_timer", bus.timer, seq_alu[i]);
            chk("alu_ir_load", bus.ir_load, seq_alu[i] == 3'b001);
            cyc();
        end

        // Memory-class instruction: retire only in MEM_D.
        bus.ir_op = 8'h83;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mem_timer", bus.timer, seq_mem[i]);
            chk("mem_retire", bus.instr_retired, ret_mem[i]);
            chk("mem_cnt", bus.retired_cnt, cnt_mem[i]);
            cyc();
        end
        bus.halt_req = 1; bus.ir_op = 8'h00;
        wait_idle("halt_idle");
        @(negedge clk);
        chk("halt_cnt", bus.retired_cnt, 4);
        chk("halt_timer", bus.timer, 3'b100);
        cyc();
        bus.halt_req = 0;

        // Fetch timeout with memory never ready.
        bus.run = 1; bus.mem_ready = 0;
        cyc();
        bus.run = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("to_timer", bus.timer, seq_to[i]);
            chk("to_retire", bus.instr_retired, 1'b0);
            cyc();
        end
        @(negedge clk);
        chk("to_err", bus.bus_err, 1'b1);
        chk("to_cnt", bus.retired_cnt, 4);
        cyc();
        bus.run = 1; bus.mem_ready = 1;
        cyc();
        bus.run = 0;
        @(negedge clk);
        chk("rerun_err", bus.bus_err, 1'b0);
        chk("rerun_timer", bus.timer, 3'b000);
        cyc();
        bus.halt_req = 1;
        wait_idle("rerun_idle");
        @(negedge clk);
        chk("rerun_cnt", bus.retired_cnt, 5);
        cyc();
        bus.halt_req = 0;

        // mem_ready arriving in the timeout cycle is a success.
        bus.run = 1; bus.mem_ready = 0;
        cyc();
        bus.run = 0;
        repeat (5) cyc();
        bus.mem_ready = 1; bus.halt_req = 1;
        @(negedge clk);
        chk("late_timer", bus.timer, 3'b001);
        chk("late_ir_load", bus.ir_load, 1'b1);
        cyc();
        @(negedge clk);
        chk("late_exec", bus.timer, 3'b011);
        chk("late_retire", bus.instr_retired, 1'b1);
        wait_idle("late_idle");
        @(negedge clk);
        chk("late_cnt", bus.retired_cnt, 6);
        chk("late_err", bus.bus_err, 1'b0);
        cyc();
        bus.halt_req = 0;

        // Reset in the middle of a MEM_D wait.
        bus.run = 1; bus.ir_op = 8'h80; bus.mem_ready = 1;
        cyc();
        bus.run = 0;
        repeat (3) cyc();
        bus.mem_ready = 0;
        repeat (2) cyc();
        @(negedge clk);
        chk("memd_timer", bus.timer, 3'b111);
        chk("memd_req", bus.mem_req, 1'b1);
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        chk("mrst_timer", bus.timer, 3'b100);
        chk("mrst_cnt", bus.retired_cnt, 0);
        chk("mrst_req", bus.mem_req, 1'b0);
        chk("mrst_busy", bus.busy, 1'b0);

        // Counter wrap: 16 retires on a 4-bit counter return it to zero.
        cyc();
        bus.run = 1; bus.ir_op = 8'h00; bus.mem_ready = 1;
        cyc();
        bus.run = 0;
        pulses = 0;
        repeat (48) begin
            @(negedge clk);
            pulses += int'(bus.instr_retired);
            cyc();
        end
        @(negedge clk);
        chk("wrap_pulses", pulses, 16);
        chk("wrap_cnt", bus.retired_cnt, 0);
        chk("wrap_timer", bus.timer, 3'b000);
        cyc();
        bus.halt_req = 1;
        wait_idle("wrap_idle");
        cyc();
        bus.halt_req = 0;

`ifdef SEQ_SINGLE_STEP_EN
        // Step mode: run executes one instruction, each step one more.
        c0 = int'(bus.retired_cnt);
        bus.step_mode = 1; bus.run = 1;
        cyc();
        bus.run = 0;
        wait_idle("step_run_idle");
        chk("step_run_cnt", bus.retired_cnt, (c0 + 1) % 16);
        for (int k = 0; k < 3; k++) begin
            bus.step = 1;
            cyc();
            bus.step = 0;
            wait_idle("step_idle");
            chk("step_cnt", bus.retired_cnt, (c0 + 2 + k) % 16);
        end
        bus.step_mode = 0;
        cyc();
`else
        c0 = 0;
`endif

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rst          = ($urandom_range(0, 299) == 0);
            bus.run      = ($urandom_range(0, 3) == 0);
            bus.halt_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bus.ir_op = {6'b100000, 2'($urandom)};
            else                           bus.ir_op = 8'($urandom);
            if ((c % 250) < 50) bus.mem_ready = ($urandom_range(0, 9) == 0);
            else                bus.mem_ready = ($urandom_range(0, 2) != 0);
`ifdef SEQ_SINGLE_STEP_EN
            bus.step = ($urandom_range(0, 19) == 0);
            if ((c % 400) == 0) bus.step_mode = 1'($urandom);
`endif
        end
        cyc();
        rst = 0;
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
